// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmio_pkg
// Purpose : Shared types and constants for the SLC-3 memory/I-O bridge.
//           FSM state encoding and the I/O window layout.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    IO     = 3'd3,
    DONE   = 3'd4
  } mmio_state_t;

  // I/O window layout, as offsets from IO_BASE
  localparam int MMIO_SW_OFF   = 0;
  localparam int MMIO_DISP_OFF = 1;
  localparam int MMIO_IO_SPAN  = 16;
  localparam int MMIO_OFF_W    = $clog2(MMIO_IO_SPAN);

endpackage

`default_nettype wire

// File: rtl/mmio_io_regs.sv
`default_nettype none
// ============================================================================
// Module  : mmio_io_regs
// Purpose : Memory-mapped I/O register file of the bridge: display register
//           bank (read/write) and switch input (read-only).
//           Build macro MMIO_SWSYNC_EN: when defined, the switches pass
//           through a two-flop synchroniser before being read.
// Ports   : clk_i, rst_ni        clock, asynchronous active-low reset
//           wr_en_i              write strobe (one cycle, in the IO state)
//           in_win_i             address lies inside the 16-word I/O window
//           off_i                offset within the I/O window
//           wdata_i              write data
//           sw_i                 board switches
//           rdata_o              read mux output (0 for unused offsets)
//           disp_o               flat display bank, channel k at [k*DATA_W +: DATA_W]
// Revision: 1.0 - initial release
// ============================================================================
module mmio_io_regs
  import mmio_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_DISP = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic                       in_win_i,
  input  logic [MMIO_OFF_W-1:0]      off_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W-1:0]          sw_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_DISP*DATA_W-1:0] disp_o
);

  logic [NUM_DISP*DATA_W-1:0] disp_q;
  logic [DATA_W-1:0]          sw_val;

`ifdef MMIO_SWSYNC_EN
  logic [DATA_W-1:0] sw_meta_q;
  logic [DATA_W-1:0] sw_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_val = sw_sync_q;
`else
  assign sw_val = sw_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      disp_q <= '0;
    end else begin
      for (int k = 0; k < NUM_DISP; k++) begin
        if (wr_en_i && in_win_i && (off_i == MMIO_OFF_W'(MMIO_DISP_OFF + k))) begin
          disp_q[k*DATA_W +: DATA_W] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (in_win_i) begin
      if (off_i == MMIO_OFF_W'(MMIO_SW_OFF)) begin
        rdata_o = sw_val;
      end
      for (int k = 0; k < NUM_DISP; k++) begin
        if (off_i == MMIO_OFF_W'(MMIO_DISP_OFF + k)) begin
          rdata_o = disp_q[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign disp_o = disp_q;

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mmio_bridge
// Purpose : SLC-3 CPU memory port to asynchronous SRAM bridge with a 4-phase
//           req/ack handshake, programmable SRAM wait states and a 16-word
//           memory-mapped I/O window (switches + display registers).
//           Build macro MMIO_SWSYNC_EN: synchronise switch inputs (see
//           mmio_io_regs).
// Ports   : Clk, Reset                     clock, async active-low reset
//           cpu_req/we/addr/wdata          CPU request side
//           cpu_rdata, cpu_ack             CPU response side
//           sram_addr, sram_*_n            SRAM address and strobes
//           sram_wdata, sram_wdata_oe      SRAM write data / tristate enable
//           sram_rdata                     SRAM read data
//           sw                             board switches
//           disp                           flat display register bank
// Revision: 1.0 - initial release
// ============================================================================
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter int                NUM_DISP    = 2,
  parameter logic [ADDR_W-1:0] IO_BASE     = {ADDR_W{1'b1}} - ADDR_W'(15)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ack,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic                       sram_ub_n,
  output logic                       sram_lb_n,
  output logic [DATA_W-1:0]          sram_wdata,
  output logic                       sram_wdata_oe,
  input  logic [DATA_W-1:0]          sram_rdata,
  input  logic [DATA_W-1:0]          sw,
  output logic [NUM_DISP*DATA_W-1:0] disp
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mmio_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;

  logic [ADDR_W-1:0] io_off;
  logic              io_in_win;
  logic [DATA_W-1:0] io_rdata;
  logic              io_wr;

  // Offset is taken from the latched address so late CPU changes are harmless
  assign io_off    = addr_q - IO_BASE;
  assign io_in_win = (io_off < ADDR_W'(MMIO_IO_SPAN));
  assign io_wr     = (state_q == IO) && we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = (cpu_addr >= IO_BASE) ? IO : SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IO:      state_d = DONE;
      DONE: begin
        if (!cpu_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Ack trails DONE by one edge; this sets the 2 / WAIT_CYCLES+2 latency
      // and drops ack one cycle after req is seen low.
      ack_q   <= (state_q == DONE);
      if ((state_q == IDLE) && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (!we_q && (state_q == ACCESS) && (cnt_q == CNT_LAST)) begin
        rdata_q <= sram_rdata;
      end
      if (!we_q && (state_q == IO)) begin
        rdata_q <= io_rdata;
      end
    end
  end

  mmio_io_regs #(
    .DATA_W   (DATA_W),
    .NUM_DISP (NUM_DISP)
  ) u_io_regs (
    .clk_i    (Clk),
    .rst_ni   (Reset),
    .wr_en_i  (io_wr),
    .in_win_i (io_in_win),
    .off_i    (io_off[MMIO_OFF_W-1:0]),
    .wdata_i  (wdata_q),
    .sw_i     (sw),
    .rdata_o  (io_rdata),
    .disp_o   (disp)
  );

  // Strobes decode straight from the state register, so an asynchronous
  // reset releases the SRAM immediately.
  assign sram_ce_n     = !((state_q == SETUP) || (state_q == ACCESS));
  assign sram_oe_n     = !((state_q == ACCESS) && !we_q);
  assign sram_we_n     = !((state_q == ACCESS) && we_q);
  assign sram_ub_n     = sram_ce_n;
  assign sram_lb_n     = sram_ce_n;
  assign sram_wdata_oe = ((state_q == SETUP) || (state_q == ACCESS)) && we_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign cpu_rdata     = rdata_q;
  assign cpu_ack       = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_bridge
// Purpose : Self-checking bench for mmio_bridge (default parameters):
//           table of directed transactions plus hand-written sequences for
//           held request, early request drop and mid-access reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;

  localparam logic [19:0] IOB = 20'hFFFF0;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_wdata_oe;
  logic [15:0] sw;
  logic [31:0] disp;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mmio_bridge dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe), .sram_rdata(sram_rdata),
    .sw(sw), .disp(disp)
  );

  // Behavioural SRAM (low address byte selects the word)
  logic [15:0] mem [256];
  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n && sram_wdata_oe) mem[sram_addr[7:0]] <= sram_wdata;
  end
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0BAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete handshake. lat counts edges from the edge that first samples
  // req until ack is seen; strobe activity is tallied along the way.
  task automatic run_txn(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                         output int lat, output int we_cyc, output int ce_cyc,
                         output int addr_bad, output logic [15:0] rd, output logic ack_after);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    @(posedge Clk); #1;
    cpu_addr = ~addr; cpu_wdata = ~wdata;   // must be ignored after edge t
    we_cyc = 0; ce_cyc = 0; addr_bad = 0;
    for (lat = 0; lat < 20; lat++) begin
      if (lat > 0) begin @(posedge Clk); #1; end
      if (!sram_we_n) we_cyc++;
      if (!sram_ce_n) begin
        ce_cyc++;
        if (sram_addr !== addr) addr_bad++;
      end
      if (cpu_ack) break;
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    for (int k = 0; k < 4 && cpu_ack; k++) begin @(posedge Clk); #1; end
    ack_after = cpu_ack;
  endtask

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] rd;
    logic [31:0] disp;
    int          lat;
    int          wecyc;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int lat, we_cyc, ce_cyc, addr_bad, n;
    logic [15:0] rd;
    logic ack_after;

    vecs[0]  = '{1'b1, 20'h00123,   16'hBEEF, 16'hA5A5, 16'h0000, 32'h0000_0000, 4, 2};
    vecs[1]  = '{1'b0, 20'h00123,   16'h0000, 16'hA5A5, 16'hBEEF, 32'h0000_0000, 4, 0};
    vecs[2]  = '{1'b1, 20'h00456,   16'h1357, 16'hA5A5, 16'hBEEF, 32'h0000_0000, 4, 2};
    vecs[3]  = '{1'b0, 20'h00123,   16'h0000, 16'hA5A5, 16'hBEEF, 32'h0000_0000, 4, 0};
    vecs[4]  = '{1'b0, 20'h00456,   16'h0000, 16'hA5A5, 16'h1357, 32'h0000_0000, 4, 0};
    vecs[5]  = '{1'b1, IOB + 20'd2, 16'h1234, 16'hA5A5, 16'h1357, 32'h1234_0000, 2, 0};
    vecs[6]  = '{1'b1, IOB + 20'd1, 16'hCAFE, 16'hA5A5, 16'h1357, 32'h1234_CAFE, 2, 0};
    vecs[7]  = '{1'b0, IOB + 20'd1, 16'h0000, 16'hA5A5, 16'hCAFE, 32'h1234_CAFE, 2, 0};
    vecs[8]  = '{1'b0, IOB + 20'd2, 16'h0000, 16'hA5A5, 16'h1234, 32'h1234_CAFE, 2, 0};
    vecs[9]  = '{1'b0, IOB,         16'h0000, 16'hA5A5, 16'hA5A5, 32'h1234_CAFE, 2, 0};
    vecs[10] = '{1'b0, IOB,         16'h0000, 16'h5A5A, 16'h5A5A, 32'h1234_CAFE, 2, 0};
    vecs[11] = '{1'b1, IOB,         16'hFFFF, 16'h5A5A, 16'h5A5A, 32'h1234_CAFE, 2, 0};
    vecs[12] = '{1'b1, IOB + 20'd9, 16'h9999, 16'hA5A5, 16'h5A5A, 32'h1234_CAFE, 2, 0};
    vecs[13] = '{1'b0, IOB + 20'd9, 16'h0000, 16'hA5A5, 16'h0000, 32'h1234_CAFE, 2, 0};
    vecs[14] = '{1'b0, IOB + 20'd1, 16'h0000, 16'hA5A5, 16'hCAFE, 32'h1234_CAFE, 2, 0};
    vecs[15] = '{1'b0, IOB + 20'd3, 16'h0000, 16'hA5A5, 16'h0000, 32'h1234_CAFE, 2, 0};
    vecs[16] = '{1'b1, IOB + 20'hF, 16'h4444, 16'hA5A5, 16'h0000, 32'h1234_CAFE, 2, 0};
    vecs[17] = '{1'b1, 20'hFFFEF,   16'h7777, 16'hA5A5, 16'h0000, 32'h1234_CAFE, 4, 2};
    vecs[18] = '{1'b0, 20'hFFFEF,   16'h0000, 16'hA5A5, 16'h7777, 32'h1234_CAFE, 4, 0};

    // ---- reset state ----
    Reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; sw = 16'hA5A5;
    #1;
    chk("rst_strobes", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_wdata_oe}, 32'b111110);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_sram_wdata", sram_wdata, 0);
    chk("rst_disp", disp, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // ---- table-driven transactions ----
    for (int i = 0; i < 19; i++) begin
      sw = vecs[i].sw;
      repeat (3) @(posedge Clk);
      #1;
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, we_cyc, ce_cyc, addr_bad, rd, ack_after);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_disp", i), disp, vecs[i].disp);
      chk($sformatf("v%0d_we_cycles", i), we_cyc, vecs[i].wecyc);
      chk($sformatf("v%0d_ce_cycles", i), ce_cyc, (vecs[i].lat == 4) ? 3 : 0);
      chk($sformatf("v%0d_addr_stable", i), addr_bad, 0);
      chk($sformatf("v%0d_ack_fall", i), ack_after, 0);
    end

    // ---- req held past ack: ack stays, no second access ----
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_addr = 20'h00456; cpu_req = 1'b1;
    @(posedge Clk); #1;
    n = 0;
    while (!cpu_ack && n < 20) begin @(posedge Clk); #1; n++; end
    chk("hold_latency", n, 4);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("hold_ack_%0d", k), cpu_ack, 1);
      chk($sformatf("hold_strobes_%0d", k), {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'b111);
    end
    chk("hold_rdata", cpu_rdata, 16'h1357);
    cpu_req = 1'b0;
    @(posedge Clk); #1;
    chk("hold_ack_last", cpu_ack, 1);
    @(posedge Clk); #1;
    chk("hold_ack_low", cpu_ack, 0);

    // ---- req dropped before ack: one-cycle ack, read still completes ----
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_addr = IOB + 20'd1; cpu_req = 1'b1;
    @(posedge Clk); #1;
    cpu_req = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      if (cpu_ack) n++;
    end
    chk("early_drop_ack_cycles", n, 1);
    chk("early_drop_rdata", cpu_rdata, 16'hCAFE);

    // ---- reset during the second ACCESS cycle of a write ----
    cpu_we = 1'b1; cpu_addr = 20'h00300; cpu_wdata = 16'h2222; cpu_req = 1'b1;
    @(posedge Clk); #1;   // SETUP
    @(posedge Clk); #1;   // ACCESS, first cycle
    @(posedge Clk); #1;   // ACCESS, second cycle
    chk("mid_we_active", sram_we_n, 0);
    Reset = 1'b0;
    #1;
    chk("mid_rst_strobes", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_wdata_oe}, 32'b111110);
    chk("mid_rst_ack", cpu_ack, 0);
    cpu_req = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("post_rst_disp", disp, 0);
    chk("post_rst_rdata", cpu_rdata, 0);
    run_txn(1'b0, IOB, 16'h0000, lat, we_cyc, ce_cyc, addr_bad, rd, ack_after);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_sw_read", rd, 16'hA5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
